fetch_stage: RTL and testbench

Instruction-fetch front end that produces the instruction word and PC+4 consumed by the IF/ID pipeline register. It owns the program counter, drives a level-sensitive instruction-memory request interface, and absorbs hazard-unit stalls and branch/jump redirects. It inserts NOP bubbles when no instruction is available, so the IF/ID register can capture this block's outputs unconditionally on every `CLK` edge.

---
 rtl/fetch_stage.sv | 91 +++++++++
 tb/tb_fetch_stage.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fetch_stage: PC owner and instruction-fetch front end for the IF/ID reg.  |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h00000000,
  parameter logic [31:0] NOP      = 32'h00000000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] out_inst,
  output logic [31:0] out_PCplus4,
  output logic        out_valid,
  output logic [31:0] fetch_count
);

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] hold_inst;
  logic [31:0] hold_pcp4;

  assign pc_plus4  = pc + 32'd4;
  assign imem_addr = pc;
  // Request is held low during reset even though the state already reads FETCH.
  assign imem_req  = (state == FETCH) && !RST;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= FETCH;
      pc          <= {RESET_PC[31:2], 2'b00};
      out_inst    <= NOP;
      out_PCplus4 <= 32'd0;
      out_valid   <= 1'b0;
      fetch_count <= 32'd0;
      hold_inst   <= NOP;
      hold_pcp4   <= 32'd0;
    end else if (redirect) begin
      // Flush: any same-cycle response and any buffered word are dropped.
      state     <= FETCH;
      pc        <= {redirect_pc[31:2], 2'b00};
      out_inst  <= NOP;
      out_valid <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (imem_ready) begin
            pc          <= pc_plus4;
            fetch_count <= fetch_count + 32'd1;
            if (stall) begin
              hold_inst <= imem_rdata;
              hold_pcp4 <= pc_plus4;
              state     <= HOLD;
            end else begin
              out_inst    <= imem_rdata;
              out_PCplus4 <= pc_plus4;
              out_valid   <= 1'b1;
            end
          end else if (!stall) begin
            out_inst  <= NOP;
            out_valid <= 1'b0;
          end
        end
        HOLD: begin
          if (!stall) begin
            out_inst    <= hold_inst;
            out_PCplus4 <= hold_pcp4;
            out_valid   <= 1'b1;
            state       <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// Directed self-checking bench for fetch_stage; memory returns addr ^ 32'hA5A5A5A5.
module tb_fetch_stage;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata;
  logic [31:0] out_inst;
  logic [31:0] out_PCplus4;
  logic        out_valid;
  logic [31:0] fetch_count;

  int compared = 0;
  int mismatched = 0;

  fetch_stage dut (
    .CLK        (CLK),
    .RST        (RST),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .out_inst   (out_inst),
    .out_PCplus4(out_PCplus4),
    .out_valid  (out_valid),
    .fetch_count(fetch_count)
  );

  always #5 CLK = ~CLK;
  assign imem_rdata = imem_addr ^ 32'hA5A5A5A5;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    compared++; if (out_inst !== 32'h0) begin mismatched++; $display("FAIL rst_inst got %h want %h", out_inst, 32'h0); end
    compared++; if (out_PCplus4 !== 32'h0) begin mismatched++; $display("FAIL rst_pcp4 got %h want %h", out_PCplus4, 32'h0); end
    compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL rst_valid got %b want 0", out_valid); end
    compared++; if (fetch_count !== 32'd0) begin mismatched++; $display("FAIL rst_count got %0d want 0", fetch_count); end
    compared++; if (imem_req !== 1'b0) begin mismatched++; $display("FAIL rst_req got %b want 0", imem_req); end
    RST = 1'b0;
    #1;
    compared++; if (imem_req !== 1'b1) begin mismatched++; $display("FAIL rel_req got %b want 1", imem_req); end
    compared++; if (imem_addr !== 32'h0) begin mismatched++; $display("FAIL rel_addr got %h want %h", imem_addr, 32'h0); end
  endtask

  task automatic test_streaming();
    logic [31:0] a;
    imem_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      a = 32'(4 * (k - 1));
      compared++; if (out_inst !== (a ^ 32'hA5A5A5A5)) begin mismatched++; $display("FAIL stream_inst[%0d] got %h want %h", k, out_inst, a ^ 32'hA5A5A5A5); end
      compared++; if (out_PCplus4 !== a + 32'd4) begin mismatched++; $display("FAIL stream_pcp4[%0d] got %h want %h", k, out_PCplus4, a + 32'd4); end
      compared++; if (out_valid !== 1'b1) begin mismatched++; $display("FAIL stream_valid[%0d] got %b want 1", k, out_valid); end
      compared++; if (fetch_count !== 32'(k)) begin mismatched++; $display("FAIL stream_count[%0d] got %0d want %0d", k, fetch_count, k); end
      compared++; if (imem_addr !== a + 32'd4) begin mismatched++; $display("FAIL stream_addr[%0d] got %h want %h", k, imem_addr, a + 32'd4); end
    end
  endtask

  task automatic test_wait_states();
    logic [31:0] a;
    for (int r = 0; r < 2; r++) begin
      a = 32'(16 + 4 * r);
      for (int w = 0; w < 2; w++) begin
        imem_ready = 1'b0;
        tick();
        compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL wait_valid[%0d.%0d] got %b want 0", r, w, out_valid); end
        compared++; if (out_inst !== 32'h0) begin mismatched++; $display("FAIL wait_inst[%0d.%0d] got %h want 0", r, w, out_inst); end
        compared++; if (out_PCplus4 !== a) begin mismatched++; $display("FAIL wait_pcp4[%0d.%0d] got %h want %h", r, w, out_PCplus4, a); end
        compared++; if (imem_addr !== a) begin mismatched++; $display("FAIL wait_addr[%0d.%0d] got %h want %h", r, w, imem_addr, a); end
      end
      imem_ready = 1'b1;
      tick();
      compared++; if (out_inst !== (a ^ 32'hA5A5A5A5)) begin mismatched++; $display("FAIL wait_inst_rdy[%0d] got %h want %h", r, out_inst, a ^ 32'hA5A5A5A5); end
      compared++; if (out_PCplus4 !== a + 32'd4) begin mismatched++; $display("FAIL wait_pcp4_rdy[%0d] got %h want %h", r, out_PCplus4, a + 32'd4); end
      compared++; if (fetch_count !== 32'(5 + r)) begin mismatched++; $display("FAIL wait_count[%0d] got %0d want %0d", r, fetch_count, 5 + r); end
      compared++; if (imem_addr !== a + 32'd4) begin mismatched++; $display("FAIL wait_addr_rdy[%0d] got %h want %h", r, imem_addr, a + 32'd4); end
    end
  endtask

  task automatic test_stall();
    imem_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h8;
    tick();
    compared++; if (imem_addr !== 32'h8) begin mismatched++; $display("FAIL stall_pre_addr got %h want %h", imem_addr, 32'h8); end
    compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL stall_pre_valid got %b want 0", out_valid); end
    compared++; if (out_PCplus4 !== 32'd24) begin mismatched++; $display("FAIL stall_pre_pcp4 got %h want %h", out_PCplus4, 32'd24); end
    redirect = 1'b0; imem_ready = 1'b1; stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      compared++; if (imem_req !== 1'b0) begin mismatched++; $display("FAIL hold_req[%0d] got %b want 0", i, imem_req); end
      compared++; if (out_valid !== 1'b0 || out_inst !== 32'h0 || out_PCplus4 !== 32'd24) begin mismatched++; $display("FAIL hold_frozen[%0d] got %b/%h/%h want 0/0/18", i, out_valid, out_inst, out_PCplus4); end
      compared++; if (fetch_count !== 32'd7) begin mismatched++; $display("FAIL hold_count[%0d] got %0d want 7", i, fetch_count); end
    end
    stall = 1'b0;
    tick();
    compared++; if (out_inst !== 32'hA5A5A5AD) begin mismatched++; $display("FAIL unstall_inst got %h want %h", out_inst, 32'hA5A5A5AD); end
    compared++; if (out_PCplus4 !== 32'd12) begin mismatched++; $display("FAIL unstall_pcp4 got %h want %h", out_PCplus4, 32'd12); end
    compared++; if (out_valid !== 1'b1) begin mismatched++; $display("FAIL unstall_valid got %b want 1", out_valid); end
    compared++; if (fetch_count !== 32'd7) begin mismatched++; $display("FAIL unstall_count got %0d want 7", fetch_count); end
    compared++; if (imem_req !== 1'b1 || imem_addr !== 32'd12) begin mismatched++; $display("FAIL unstall_req got %b/%h want 1/%h", imem_req, imem_addr, 32'd12); end
    imem_ready = 1'b0; stall = 1'b1;
    tick();
    compared++; if (out_valid !== 1'b1 || out_inst !== 32'hA5A5A5AD) begin mismatched++; $display("FAIL idle_stall got %b/%h want 1/%h", out_valid, out_inst, 32'hA5A5A5AD); end
    stall = 1'b0;
    tick();
    compared++; if (out_valid !== 1'b0 || out_inst !== 32'h0 || out_PCplus4 !== 32'd12) begin mismatched++; $display("FAIL idle_bubble got %b/%h/%h want 0/0/c", out_valid, out_inst, out_PCplus4); end
  endtask

  task automatic test_redirect();
    imem_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h00000103;
    tick();
    compared++; if (out_valid !== 1'b0 || out_inst !== 32'h0) begin mismatched++; $display("FAIL redir_rdy_out got %b/%h want 0/0", out_valid, out_inst); end
    compared++; if (fetch_count !== 32'd7) begin mismatched++; $display("FAIL redir_rdy_count got %0d want 7", fetch_count); end
    compared++; if (imem_addr !== 32'h100) begin mismatched++; $display("FAIL redir_rdy_addr got %h want %h", imem_addr, 32'h100); end
    compared++; if (out_PCplus4 !== 32'd12) begin mismatched++; $display("FAIL redir_rdy_pcp4 got %h want %h", out_PCplus4, 32'd12); end
    redirect = 1'b0; stall = 1'b1;
    tick();
    compared++; if (imem_req !== 1'b0 || fetch_count !== 32'd8) begin mismatched++; $display("FAIL redir_hold_entry got %b/%0d want 0/8", imem_req, fetch_count); end
    redirect = 1'b1; imem_ready = 1'b0;
    tick();
    compared++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin mismatched++; $display("FAIL redir_hold_addr got %b/%h want 1/%h", imem_req, imem_addr, 32'h100); end
    compared++; if (out_valid !== 1'b0 || fetch_count !== 32'd8) begin mismatched++; $display("FAIL redir_hold_out got %b/%0d want 0/8", out_valid, fetch_count); end
    redirect = 1'b0; stall = 1'b0;
    tick();
    compared++; if (out_valid !== 1'b0 || out_inst !== 32'h0 || out_PCplus4 !== 32'd12) begin mismatched++; $display("FAIL redir_buf_dropped got %b/%h/%h want 0/0/c", out_valid, out_inst, out_PCplus4); end
    imem_ready = 1'b1;
    tick();
    compared++; if (out_inst !== 32'hA5A5A4A5 || out_PCplus4 !== 32'h104) begin mismatched++; $display("FAIL redir_resume got %h/%h want a5a5a4a5/104", out_inst, out_PCplus4); end
    compared++; if (fetch_count !== 32'd9) begin mismatched++; $display("FAIL redir_resume_count got %0d want 9", fetch_count); end
  endtask

  task automatic test_wrap();
    imem_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'hFFFFFFFC;
    tick();
    compared++; if (imem_addr !== 32'hFFFFFFFC) begin mismatched++; $display("FAIL wrap_addr got %h want %h", imem_addr, 32'hFFFFFFFC); end
    redirect = 1'b0; imem_ready = 1'b1;
    tick();
    compared++; if (out_inst !== 32'h5A5A5A59) begin mismatched++; $display("FAIL wrap_inst got %h want %h", out_inst, 32'h5A5A5A59); end
    compared++; if (out_PCplus4 !== 32'h0) begin mismatched++; $display("FAIL wrap_pcp4 got %h want 0", out_PCplus4); end
    compared++; if (imem_addr !== 32'h0) begin mismatched++; $display("FAIL wrap_next_addr got %h want 0", imem_addr); end
    compared++; if (fetch_count !== 32'd10) begin mismatched++; $display("FAIL wrap_count got %0d want 10", fetch_count); end
  endtask

  task automatic test_async_reset();
    stall = 1'b1; imem_ready = 1'b1;
    tick();
    compared++; if (imem_req !== 1'b0 || fetch_count !== 32'd11) begin mismatched++; $display("FAIL ar_hold got %b/%0d want 0/11", imem_req, fetch_count); end
    #2 RST = 1'b1;
    #1;
    compared++; if (out_inst !== 32'h0 || out_PCplus4 !== 32'h0 || out_valid !== 1'b0) begin mismatched++; $display("FAIL ar_outputs got %h/%h/%b want 0/0/0", out_inst, out_PCplus4, out_valid); end
    compared++; if (fetch_count !== 32'd0 || imem_req !== 1'b0) begin mismatched++; $display("FAIL ar_count_req got %0d/%b want 0/0", fetch_count, imem_req); end
    #2 RST = 1'b0; stall = 1'b0; imem_ready = 1'b0;
    #1;
    compared++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin mismatched++; $display("FAIL ar_release got %b/%h want 1/0", imem_req, imem_addr); end
    tick();
    compared++; if (out_valid !== 1'b0 || out_inst !== 32'h0) begin mismatched++; $display("FAIL ar_buf_lost got %b/%h want 0/0", out_valid, out_inst); end
    imem_ready = 1'b1;
    tick();
    compared++; if (out_inst !== 32'hA5A5A5A5 || out_PCplus4 !== 32'd4 || out_valid !== 1'b1) begin mismatched++; $display("FAIL ar_resume got %h/%h/%b want a5a5a5a5/4/1", out_inst, out_PCplus4, out_valid); end
    compared++; if (fetch_count !== 32'd1) begin mismatched++; $display("FAIL ar_resume_count got %0d want 1", fetch_count); end
  endtask

  initial begin
    #1;
    test_reset();
    test_streaming();
    test_wait_states();
    test_stall();
    test_redirect();
    test_wrap();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
